// File: rtl/stack_ras_pkg.sv
// Shared definitions for the return-address stack.
// - clog2: ceiling log2, used to size the write index and the count output.
// - depth_legal: the elaboration-time range check for DEPTH (2..256).
package stack_ras_pkg;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 256;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit depth_legal(input int d);
    return (d >= DEPTH_MIN) && (d <= DEPTH_MAX);
  endfunction

endpackage

// File: rtl/stack_ras_mem.sv
// Entry storage for the return-address stack.
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port. Contents are never reset.
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   waddr  write index (always < DEPTH)
//   wdata  write data
//   raddr  read index (always < DEPTH)
//   rdata  combinational read data
module stack_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_ras.sv
// Parametrised return-address stack for CALL/RET and interrupt entry/return.
// The storage is a ring of DEPTH entries; wp is the next write index and the
// top entry lives at (wp-1) mod DEPTH. All index arithmetic wraps explicitly at
// DEPTH, so non-power-of-two depths work.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset (control state only)
//   push       push push_data at the next edge
//   pop        discard the top entry at the next edge
//   push_data  entry to push (normally the current PC)
//   err_clr    clear the sticky ovf/udf flags
//   top        current top entry, combinational, 0 when empty
//   count      occupancy 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   ovf        sticky overflow (push while full)
//   udf        sticky underflow (pop while empty)
module stack_ras
  import stack_ras_pkg::*;
#(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 8,
  parameter  int WRAP  = 0,
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             err_clr,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             udf
);

  localparam int AW = clog2(DEPTH);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("stack_ras: DEPTH must be in 2..256");
  end

  logic [AW-1:0]    wp_p1;
  logic [CW-1:0]    count_p1;
  logic             ovf_p1;
  logic             udf_p1;

  logic [AW-1:0]    wp_inc;
  logic [AW-1:0]    wp_dec;
  logic [AW-1:0]    wp_nxt;
  logic [AW-1:0]    waddr;
  logic [CW-1:0]    count_nxt;
  logic             we_req;
  logic             ovf_set;
  logic             udf_set;
  logic             is_empty;
  logic             is_full;
  logic [WIDTH-1:0] rd_data;

  // Stage p0: index arithmetic and operation decode
  assign wp_inc   = (wp_p1 == AW'(DEPTH - 1)) ? '0 : wp_p1 + AW'(1);
  assign wp_dec   = (wp_p1 == '0) ? AW'(DEPTH - 1) : wp_p1 - AW'(1);
  assign is_empty = (count_p1 == '0);
  assign is_full  = (count_p1 == CW'(DEPTH));

  always_comb begin
    we_req    = 1'b0;
    waddr     = wp_p1;
    wp_nxt    = wp_p1;
    count_nxt = count_p1;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    if (push && pop) begin
      if (is_empty) begin
        // Nothing to replace: behave as a plain push but flag the bad pop.
        we_req    = 1'b1;
        wp_nxt    = wp_inc;
        count_nxt = CW'(1);
        udf_set   = 1'b1;
      end else begin
        // Tail-call replace: overwrite the top in place, even when full.
        we_req = 1'b1;
        waddr  = wp_dec;
      end
    end else if (push) begin
      if (!is_full) begin
        we_req    = 1'b1;
        wp_nxt    = wp_inc;
        count_nxt = count_p1 + CW'(1);
      end else begin
        ovf_set = 1'b1;
        if (WRAP != 0) begin
          // Ring is full, so wp already points at the oldest entry.
          we_req = 1'b1;
          wp_nxt = wp_inc;
        end
      end
    end else if (pop) begin
      if (!is_empty) begin
        wp_nxt    = wp_dec;
        count_nxt = count_p1 - CW'(1);
      end else begin
        udf_set = 1'b1;
      end
    end
  end

  // Stage p1: registered control state (reset has priority, even over writes)
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_p1    <= '0;
      count_p1 <= '0;
      ovf_p1   <= 1'b0;
      udf_p1   <= 1'b0;
    end else begin
      wp_p1    <= wp_nxt;
      count_p1 <= count_nxt;
      // A new error in the same cycle as err_clr wins.
      ovf_p1   <= ovf_set | (ovf_p1 & ~err_clr);
      udf_p1   <= udf_set | (udf_p1 & ~err_clr);
    end
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we_req & reset),
    .waddr (waddr),
    .wdata (push_data),
    .raddr (wp_dec),
    .rdata (rd_data)
  );

  assign top   = is_empty ? '0 : rd_data;
  assign count = count_p1;
  assign empty = is_empty;
  assign full  = is_full;
  assign ovf   = ovf_p1;
  assign udf   = udf_p1;

endmodule

// File: tb/tb_stack_ras.sv
// Bench for stack_ras: three instances (DEPTH=4 refuse, DEPTH=4 circular,
// DEPTH=3 refuse) driven one at a time and compared against a plain-array
// stack model plus directed constants.
module tb_stack_ras;

  logic       clk;
  logic       rst_n;
  logic       p_push [3];
  logic       p_pop  [3];
  logic       p_clr  [3];
  logic [9:0] p_data [3];
  logic [9:0] top_o  [3];
  logic       empty_o[3];
  logic       full_o [3];
  logic       ovf_o  [3];
  logic       udf_o  [3];
  logic [2:0] cnt0;
  logic [2:0] cnt1;
  logic [1:0] cnt2;
  logic [3:0] cnt_o  [3];

  assign cnt_o[0] = {1'b0, cnt0};
  assign cnt_o[1] = {1'b0, cnt1};
  assign cnt_o[2] = {2'b00, cnt2};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a stack held bottom-first in a plain array.
  int         dep[3] = '{4, 4, 3};
  bit         wrp[3] = '{1'b0, 1'b1, 1'b0};
  logic [9:0] ms [3][256];
  int         msz[3];
  bit         mov[3];
  bit         mud[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stack_ras #(.WIDTH(10), .DEPTH(4), .WRAP(0)) u0 (
    .clk(clk), .reset(rst_n), .push(p_push[0]), .pop(p_pop[0]),
    .push_data(p_data[0]), .err_clr(p_clr[0]), .top(top_o[0]), .count(cnt0),
    .empty(empty_o[0]), .full(full_o[0]), .ovf(ovf_o[0]), .udf(udf_o[0]));

  stack_ras #(.WIDTH(10), .DEPTH(4), .WRAP(1)) u1 (
    .clk(clk), .reset(rst_n), .push(p_push[1]), .pop(p_pop[1]),
    .push_data(p_data[1]), .err_clr(p_clr[1]), .top(top_o[1]), .count(cnt1),
    .empty(empty_o[1]), .full(full_o[1]), .ovf(ovf_o[1]), .udf(udf_o[1]));

  stack_ras #(.WIDTH(10), .DEPTH(3), .WRAP(0)) u2 (
    .clk(clk), .reset(rst_n), .push(p_push[2]), .pop(p_pop[2]),
    .push_data(p_data[2]), .err_clr(p_clr[2]), .top(top_o[2]), .count(cnt2),
    .empty(empty_o[2]), .full(full_o[2]), .ovf(ovf_o[2]), .udf(udf_o[2]));

  function automatic logic [9:0] model_top(input int k);
    return (msz[k] == 0) ? 10'd0 : ms[k][msz[k]-1];
  endfunction

  task automatic model_update(input int k, input bit ps, input bit pp,
                              input bit clr, input logic [9:0] d);
    bit ovs;
    bit uds;
    ovs = 1'b0;
    uds = 1'b0;
    if (ps && pp) begin
      if (msz[k] == 0) begin
        ms[k][0] = d;
        msz[k] = 1;
        uds = 1'b1;
      end else begin
        ms[k][msz[k]-1] = d;
      end
    end else if (ps) begin
      if (msz[k] < dep[k]) begin
        ms[k][msz[k]] = d;
        msz[k] = msz[k] + 1;
      end else begin
        ovs = 1'b1;
        if (wrp[k]) begin
          for (int i = 0; i < msz[k] - 1; i++) ms[k][i] = ms[k][i+1];
          ms[k][msz[k]-1] = d;
        end
      end
    end else if (pp) begin
      if (msz[k] > 0) msz[k] = msz[k] - 1;
      else uds = 1'b1;
    end
    mov[k] = ovs | (mov[k] & ~clr);
    mud[k] = uds | (mud[k] & ~clr);
  endtask

  // One clock edge on instance k; outputs are settled when this returns.
  task automatic step(input int k, input bit ps, input bit pp, input bit clr,
                      input logic [9:0] d);
    p_push[k] = ps;
    p_pop[k]  = pp;
    p_clr[k]  = clr;
    p_data[k] = d;
    @(posedge clk);
    model_update(k, ps, pp, clr, d);
    #1;
    p_push[k] = 1'b0;
    p_pop[k]  = 1'b0;
    p_clr[k]  = 1'b0;
    p_data[k] = 10'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      msz[k] = 0;
      mov[k] = 1'b0;
      mud[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) step(k, 1'b0, 1'b0, 1'b0, 10'd0);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({cnt_o[k], empty_o[k], full_o[k], top_o[k], ovf_o[k], udf_o[k]} !==
          {4'd0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_state inst=%0d cnt=%0d empty=%b full=%b top=%h ovf=%b udf=%b required 0/1/0/000/0/0",
                 k, cnt_o[k], empty_o[k], full_o[k], top_o[k], ovf_o[k], udf_o[k]);
      end
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(0, 1'b1, 1'b0, 1'b0, 10'(i));
      n_tests++;
      if ({cnt_o[0], top_o[0], full_o[0]} !== {4'(i), 10'(i), (i == 4)}) begin
        n_fail++;
        $display("FAIL fill_push%0d cnt=%0d top=%h full=%b required %0d/%h/%b",
                 i, cnt_o[0], top_o[0], full_o[0], i, 10'(i), (i == 4));
      end
    end
    step(0, 1'b1, 1'b0, 1'b0, 10'h3FF);
    n_tests++;
    if ({ovf_o[0], top_o[0], cnt_o[0]} !== {1'b1, 10'h004, 4'd4}) begin
      n_fail++;
      $display("FAIL push_when_full ovf=%b top=%h cnt=%0d required 1/004/4",
               ovf_o[0], top_o[0], cnt_o[0]);
    end
    for (int i = 4; i >= 1; i--) begin
      n_tests++;
      if (top_o[0] !== 10'(i)) begin
        n_fail++;
        $display("FAIL pop_order top=%h required %h", top_o[0], 10'(i));
      end
      step(0, 1'b0, 1'b1, 1'b0, 10'd0);
    end
    n_tests++;
    if ({cnt_o[0], empty_o[0], top_o[0], ovf_o[0]} !== {4'd0, 1'b1, 10'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL drained cnt=%0d empty=%b top=%h ovf=%b required 0/1/000/1",
               cnt_o[0], empty_o[0], top_o[0], ovf_o[0]);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(0, 1'b0, 1'b1, 1'b0, 10'd0);
    n_tests++;
    if ({udf_o[0], cnt_o[0]} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL pop_empty udf=%b cnt=%0d required 1/0", udf_o[0], cnt_o[0]);
    end
    step(0, 1'b0, 1'b0, 1'b1, 10'd0);
    n_tests++;
    if (udf_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr udf=%b required 0", udf_o[0]);
    end
    step(0, 1'b0, 1'b1, 1'b1, 10'd0);
    n_tests++;
    if ({udf_o[0], cnt_o[0]} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL clr_vs_set udf=%b cnt=%0d required 1/0", udf_o[0], cnt_o[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1'b1, 1'b0, 1'b0, 10'h010 + 10'(i));
    n_tests++;
    if ({ovf_o[1], cnt_o[1], full_o[1]} !== {1'b1, 4'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_fill ovf=%b cnt=%0d full=%b required 1/4/1",
               ovf_o[1], cnt_o[1], full_o[1]);
    end
    for (int i = 5; i >= 2; i--) begin
      n_tests++;
      if (top_o[1] !== 10'h010 + 10'(i)) begin
        n_fail++;
        $display("FAIL wrap_pop top=%h required %h", top_o[1], 10'h010 + 10'(i));
      end
      step(1, 1'b0, 1'b1, 1'b0, 10'd0);
    end
    n_tests++;
    if (udf_o[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_no_early_udf udf=%b required 0", udf_o[1]);
    end
    step(1, 1'b0, 1'b1, 1'b0, 10'd0);
    n_tests++;
    if ({udf_o[1], cnt_o[1]} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL wrap_udf udf=%b cnt=%0d required 1/0", udf_o[1], cnt_o[1]);
    end
  endtask

  task automatic test_replace();
    do_reset();
    step(0, 1'b1, 1'b0, 1'b0, 10'h100);
    step(0, 1'b1, 1'b0, 1'b0, 10'h200);
    step(0, 1'b1, 1'b1, 1'b0, 10'h2AA);
    n_tests++;
    if ({cnt_o[0], top_o[0], ovf_o[0], udf_o[0]} !== {4'd2, 10'h2AA, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL replace cnt=%0d top=%h ovf=%b udf=%b required 2/2aa/0/0",
               cnt_o[0], top_o[0], ovf_o[0], udf_o[0]);
    end
    step(0, 1'b0, 1'b1, 1'b0, 10'd0);
    n_tests++;
    if ({cnt_o[0], top_o[0]} !== {4'd1, 10'h100}) begin
      n_fail++;
      $display("FAIL replace_pop cnt=%0d top=%h required 1/100", cnt_o[0], top_o[0]);
    end
    step(0, 1'b0, 1'b1, 1'b0, 10'd0);
    step(0, 1'b1, 1'b1, 1'b0, 10'h055);
    n_tests++;
    if ({cnt_o[0], top_o[0], udf_o[0]} !== {4'd1, 10'h055, 1'b1}) begin
      n_fail++;
      $display("FAIL replace_empty cnt=%0d top=%h udf=%b required 1/055/1",
               cnt_o[0], top_o[0], udf_o[0]);
    end
    // Replace while full must not raise ovf.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 1'b0, 10'h020 + 10'(i));
    step(0, 1'b1, 1'b1, 1'b0, 10'h1EE);
    n_tests++;
    if ({cnt_o[0], top_o[0], ovf_o[0]} !== {4'd4, 10'h1EE, 1'b0}) begin
      n_fail++;
      $display("FAIL replace_full cnt=%0d top=%h ovf=%b required 4/1ee/0",
               cnt_o[0], top_o[0], ovf_o[0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      do_reset();
      for (int n = 0; n < 80; n++) begin
        int         op;
        bit         clr;
        logic [9:0] d;
        op  = $urandom_range(0, 9);
        clr = ($urandom_range(0, 7) == 0);
        d   = 10'($urandom_range(0, 1023));
        // Push-heavy and pop-heavy bursts keep the ring crossing its wrap point.
        if (((n / 8) % 2) == 0) begin
          if (op < 6) step(k, 1'b1, 1'b0, clr, d);
          else if (op < 8) step(k, 1'b0, 1'b1, clr, d);
          else if (op < 9) step(k, 1'b1, 1'b1, clr, d);
          else step(k, 1'b0, 1'b0, clr, d);
        end else begin
          if (op < 6) step(k, 1'b0, 1'b1, clr, d);
          else if (op < 8) step(k, 1'b1, 1'b0, clr, d);
          else if (op < 9) step(k, 1'b1, 1'b1, clr, d);
          else step(k, 1'b0, 1'b0, clr, d);
        end
        n_tests++;
        if ({cnt_o[k], top_o[k], empty_o[k], full_o[k], ovf_o[k], udf_o[k]} !==
            {4'(msz[k]), model_top(k), (msz[k] == 0), (msz[k] == dep[k]), mov[k], mud[k]}) begin
          n_fail++;
          $display("FAIL random inst=%0d n=%0d cnt=%0d top=%h e=%b f=%b o=%b u=%b required %0d/%h/%b/%b/%b/%b",
                   k, n, cnt_o[k], top_o[k], empty_o[k], full_o[k], ovf_o[k], udf_o[k],
                   msz[k], model_top(k), (msz[k] == 0), (msz[k] == dep[k]), mov[k], mud[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    step(2, 1'b1, 1'b0, 1'b0, 10'h0A1);
    step(2, 1'b1, 1'b0, 1'b0, 10'h0A2);
    n_tests++;
    if ({cnt_o[2], top_o[2]} !== {4'd2, 10'h0A2}) begin
      n_fail++;
      $display("FAIL pre_reset cnt=%0d top=%h required 2/0a2", cnt_o[2], top_o[2]);
    end
    // Reset wins over a simultaneous push.
    p_push[2] = 1'b1;
    p_data[2] = 10'h3C3;
    do_reset();
    p_push[2] = 1'b0;
    p_data[2] = 10'd0;
    n_tests++;
    if ({cnt_o[2], top_o[2], empty_o[2]} !== {4'd0, 10'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_midway cnt=%0d top=%h empty=%b required 0/000/1",
               cnt_o[2], top_o[2], empty_o[2]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p_push[k] = 1'b0;
      p_pop[k]  = 1'b0;
      p_clr[k]  = 1'b0;
      p_data[k] = 10'd0;
      msz[k]    = 0;
      mov[k]    = 1'b0;
      mud[k]    = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill_overflow();
    test_underflow();
    test_wrap();
    test_replace();
    test_random();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_ras.md
Name: stack_ras

Overview:
Parametrised return-address stack, the successor to the fixed 10-bit subroutine stack in the single-cycle CPU datapath.
- Holds return PCs (and optionally saved flags packed into the word) for CALL/RET and interrupt entry/return.
- Generalised in width and depth; adds occupancy, full/empty, sticky overflow/underflow errors, simultaneous push+pop (tail-call replace) and an optional circular overwrite mode.
- Sits between the PC register and the PC-source mux: the top-of-stack output drives the mux input directly.

Parameters:
WIDTH, 10, bits per entry (PC width, plus flag bits if packed by the caller)
DEPTH, 8, number of entries; legal range 2..256, power of two not required
WRAP, 0, 0 = refuse push when full; 1 = circular, overwrite the oldest entry when full
CW, clog2(DEPTH+1), width of the count output (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
push  in  1  push push_data at the next edge
pop  in  1  discard top at the next edge
push_data  in  WIDTH  entry to push, normally the current PC
err_clr  in  1  clears ovf/udf
top  out  WIDTH  current top entry, combinational; 0 when empty
count  out  CW  occupancy 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
ovf  out  1  sticky overflow (push while full)
udf  out  1  sticky underflow (pop while empty)

Behaviour:
- Storage is a ring of DEPTH entries. wp is the next write index. count is the occupancy. top = mem[(wp-1) mod DEPTH].
- All index arithmetic is explicit modulo DEPTH, so non-power-of-two DEPTH is valid.
- Reset (reset==0 at a posedge) has priority over everything:
  - wp=0, count=0, ovf=0, udf=0; outputs empty=1, full=0, top=0.
  - mem contents are not cleared.
  - A reset asserted mid-sequence discards all entries in that cycle.
- top is zero-latency (read before the edge), so the PC mux can take the RET target in the same cycle that pop is asserted.
- Per-edge actions (reset==1):
  - idle (push=0, pop=0): no change.
  - push, not full: mem[wp]<=push_data; wp<=wp+1; count<=count+1.
  - push, full, WRAP=0: no state change; ovf<=1.
  - push, full, WRAP=1: mem[wp]<=push_data; wp<=wp+1; count stays DEPTH; ovf<=1 (an entry was lost).
  - pop, not empty: wp<=wp-1; count<=count-1.
  - pop, empty: no state change; udf<=1.
  - push+pop, not empty: replace the top, mem[wp-1]<=push_data; wp and count unchanged; no error, even when full.
  - push+pop, empty: acts as a plain push (count becomes 1); udf<=1.
- err_clr clears ovf/udf at the edge. If a new error occurs in the same cycle, set wins.
- Flags and count are registered. empty/full decode from count and are valid in the cycle after the edge.
- No internal latency beyond one edge per operation. No handshake: every request completes in the cycle it is presented.

Decomposition:
- Shared package/include: clog2 constant function and the legal-range check for DEPTH (elaboration error if DEPTH<2 or DEPTH>256).
- One natural sub-module: stack_mem (DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port, no reset).
- The controller (wp, count, flags) stays in stack_ras.
- The datapath integration (mux_stack select, pop/push decode from opcode) remains in the control unit.

Test Plan:
- Reset then idle → count=0, empty=1, full=0, top=0, ovf=udf=0.
- (WIDTH=10, DEPTH=4, WRAP=0) push 0x001, 0x002, 0x003, 0x004 → count=4, full=1, top=0x004. A 5th push of 0x3FF → ovf=1, top stays 0x004, count=4. Then 4 pops → top sequence 0x004, 0x003, 0x002, 0x001, then count=0, empty=1.
- Same config: pop while empty → udf=1, count=0. Assert err_clr alone → udf=0. Assert err_clr together with another empty pop → udf stays 1.
- WRAP=1, DEPTH=4: push 0x010..0x015 (6 pushes) → ovf=1, count=4. Pops return 0x015, 0x014, 0x013, 0x012, then udf on the 5th pop.
- Push 0x100, 0x200, then push+pop with 0x2AA → count=2, top=0x2AA. Pop → top=0x100. Then push+pop on empty with 0x055 → count=1, top=0x055, udf=1.
- DEPTH=3 (non-power-of-two): 10 alternating push/pop bursts around the index wrap point, compared against a reference model → top and count always match. Reset asserted with count=2 → count=0, top=0 in the next cycle.
